// File: rtl/legv8_mem_arbiter.sv
// legv8_mem_arbiter: shares one single-ported, fixed-latency unified memory
// between the instruction-fetch port and the load/store port of the LEGv8 core.
// Accesses are serialised as IDLE -> ACCESS (MEM_LATENCY cycles) -> DONE.
// Optional feature macro: LEGV8_MEM_ARB_RR_EN selects round-robin arbitration
// on simultaneous requests; when undefined, data always beats fetch.
module legv8_mem_arbiter #(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              restart_cpu,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              pick_data;
    logic              owner_data;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [CNT_W-1:0]  cnt;

`ifdef LEGV8_MEM_ARB_RR_EN
    logic              last_owner_data;
`endif

    // State register; a synchronous restart drops any in-flight access.
    always_ff @(posedge clk) begin
        if (restart_cpu) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode, arbitration choice and memory-side strobes.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        mem_en     = 1'b0;
        busy       = (state != IDLE);
`ifdef LEGV8_MEM_ARB_RR_EN
        pick_data  = d_req && !(if_req && last_owner_data);
`else
        pick_data  = d_req;
`endif
        case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    accept     = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                mem_en = 1'b1;
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        mem_we = mem_en && lat_we;
    end

    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

    // Request latching, latency counter and registered gnt/rvalid/rdata pulses.
    always_ff @(posedge clk) begin
        if (restart_cpu) begin
            owner_data <= 1'b1;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            cnt        <= '0;
            if_gnt     <= 1'b0;
            d_gnt      <= 1'b0;
            if_rvalid  <= 1'b0;
            d_rvalid   <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner_data <= pick_data;
                        lat_we     <= pick_data && d_we;
                        lat_addr   <= pick_data ? d_addr : if_addr;
                        lat_wdata  <= pick_data ? d_wdata : '0;
                        cnt        <= CNT_W'(MEM_LATENCY - 1);
                        if_gnt     <= !pick_data;
                        d_gnt      <= pick_data;
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (owner_data) begin
                        d_rvalid <= 1'b1;
                        if (!lat_we) begin
                            d_rdata <= mem_rdata;
                        end
                    end else begin
                        if_rvalid <= 1'b1;
                        if_rdata  <= mem_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef LEGV8_MEM_ARB_RR_EN
    // Remembers who owned the most recent grant so ties alternate.
    always_ff @(posedge clk) begin
        if (restart_cpu) begin
            last_owner_data <= 1'b1;
        end else if (accept) begin
            last_owner_data <= pick_data;
        end
    end
`endif

endmodule

// File: doc/legv8_mem_arbiter.md
Name: legv8_mem_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the LEGv8 instruction-fetch stage and the load/store (data) stage.
- Sits between the core pipeline and the memory model inside the LEGv8 top level.
- Selects one requester, drives the memory for MEM_LATENCY cycles, then returns read data or write completion to the owner.
- Serialises all accesses; the core stalls on missing grant/rvalid.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width
MEM_LATENCY, 2, cycles mem_en is held per access; legal range >= 1

Ports:
clk  in  1  system clock, rising edge
restart_cpu  in  1  reset, synchronous, active-high
if_req  in  1  fetch request; held until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  one-cycle pulse: fetch request accepted
if_rvalid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  DATA_W  fetched instruction word
d_req  in  1  data request; held until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_gnt  out  1  one-cycle pulse: data request accepted
d_rvalid  out  1  one-cycle pulse: load data valid or store complete
d_rdata  out  DATA_W  load data
mem_en  out  1  memory access active
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid in last access cycle
busy  out  1  high whenever state != IDLE

Behaviour:
Reset values:
- Reset is synchronous: restart_cpu high at a rising edge forces state IDLE.
- All outputs are 0, including if_rdata and d_rdata.
- Wait counter is 0; last-owner flag = DATA.

State IDLE:
- Both requests are sampled on the clock edge.
- If no request is present, remain in IDLE.
- Otherwise:
  - choose the owner per the priority rules;
  - latch addr, we and wdata;
  - load counter = MEM_LATENCY-1;
  - go to ACCESS.

State ACCESS:
- Occupies cycles 1..MEM_LATENCY after acceptance.
- Owner's gnt is high only in the first ACCESS cycle, as a registered pulse.
- mem_en = 1 for all ACCESS cycles.
- mem_addr, mem_we and mem_wdata hold the latched values for all ACCESS cycles.
- mem_we = 0 for fetches.
- Counter decrements each cycle.
- At counter == 0:
  - capture mem_rdata for loads and fetches;
  - go to DONE.

State DONE:
- Lasts one cycle.
- Owner's rvalid = 1 for this cycle.
- For reads, the owner's rdata is updated in this cycle.
- For stores, d_rdata keeps its previous value.
- mem_en = 0.
- Next state is IDLE; no request is accepted in DONE.

Timing:
- Request sampled in IDLE at cycle 0: gnt in cycle 1, rvalid in cycle MEM_LATENCY+1.
- Peak throughput: one access per MEM_LATENCY+2 cycles.

Output holding:
- if_rdata and d_rdata hold their values between rvalid pulses.
- The non-owner's gnt and rvalid stay 0 during an access.

Requester handshake:
- A requester must hold req, addr and data stable until its gnt.
- It may drop or change them from the cycle after gnt.
- A request still asserted after gnt is treated as a new request at the next IDLE.

Priority (default, macro undefined):
- Fixed: when both requests are present, data wins.
- Fetch is served on the next IDLE in which d_req is low.

Boundary conditions:
- MEM_LATENCY = 1: ACCESS lasts exactly one cycle; gnt and mem_en coincide.
- Reset asserted during ACCESS or DONE:
  - the in-flight access is dropped;
  - no rvalid is produced;
  - mem_en = 0 from the next cycle;
  - the memory may have completed a partial store, which is acceptable.
- Request arriving during ACCESS/DONE: not sampled until IDLE.
- Address is passed through unmodified; there is no alignment check.

Optional Feature:
Macro: LEGV8_MEM_ARB_RR_EN
- Defined:
  - round-robin priority on simultaneous requests, granting the requester that did not own the previous access;
  - last-owner flag updates on every grant;
  - after reset, last-owner = DATA, so the first tie goes to fetch;
  - a lone request is always granted regardless of the flag.
- Undefined:
  - fixed data-over-fetch priority;
  - last-owner flag is absent.

Test Plan:
All scenarios use MEM_LATENCY=2; cycle 0 = request sampled in IDLE.
1. Reset: restart_cpu=1 for 2 cycles with if_req=1, d_req=1 -> all outputs 0, no gnt; cycle 0 is then the first cycle after release.
2. Lone fetch, if_addr=0x40, mem_rdata=0xD2800020 -> if_gnt=1 in cycle 1; mem_en=1 with mem_addr=0x40 and mem_we=0 in cycles 1-2; if_rvalid=1 with if_rdata=0xD2800020 in cycle 3; busy low in cycle 4.
3. Store, d_addr=0x100, d_wdata=0xDEAD, d_we=1 -> mem_we=1 with mem_wdata=0xDEAD in cycles 1-2; d_rvalid=1 in cycle 3; d_rdata unchanged; if_rvalid stays 0.
4. Simultaneous if_req and d_req, both held:
   - without macro: d_gnt in cycle 1, if_gnt in cycle 5;
   - with LEGV8_MEM_ARB_RR_EN: if_gnt in cycle 1, d_gnt in cycle 5.
5. Load started, restart_cpu=1 in cycle 2 -> no d_rvalid in cycle 3; mem_en=0 in cycle 3; state IDLE.
6. if_req held high continuously, d_req=0 -> if_gnt pulses in cycles 1, 5, 9 and if_rvalid in cycles 3, 7, 11.
